// File: rtl/rca_ctrl_pkg.sv
// Shared types and limits for the ripple-carry adder share controller.
package rca_ctrl_pkg;

  localparam int RCA_DATA_W     = 32;
  localparam int RCA_SETTLE_MAX = 15;
  localparam int RCA_CNT_W      = $clog2(RCA_SETTLE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } rca_ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the requester
// that was not granted whenever the owner of the last grant is finished.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic rr_ptr_q, rr_ptr_d;
  logic last_id_q, last_id_d;

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = rr_ptr_q ? 2'b10 : 2'b01;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end

    // Between grants, gnt_id reports the owner of the most recent grant.
    gnt_id    = (gnt != 2'b00) ? gnt[1] : last_id_q;
    last_id_d = gnt_id;
    rr_ptr_d  = advance ? ~last_id_q : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= 1'b0;
      last_id_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      last_id_q <= last_id_d;
    end
  end

endmodule

// File: rtl/rca_share_ctrl.sv
// Sequencer and two-port arbiter driving the shared ripple-carry adder:
// grant, hold add_en for a settle window, capture the sum, return it.
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches operands
// SETTLE | add_en high while the ripple chain resolves
// RESP   | sum presented on the granted requester's response channel
module rca_share_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DATA_W        = RCA_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              add_en,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_z,
  output logic              busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > RCA_SETTLE_MAX) begin : g_bad_settle
    $error("rca_share_ctrl: SETTLE_CYCLES must be within 1..%0d", RCA_SETTLE_MAX);
  end
  if (DATA_W != RCA_DATA_W) begin : g_bad_width
    $error("rca_share_ctrl: DATA_W must equal %0d", RCA_DATA_W);
  end

  localparam logic [RCA_CNT_W-1:0] SETTLE_LOAD = RCA_CNT_W'(SETTLE_CYCLES - 1);

  rca_ctrl_state_t       state_q, state_d;
  logic [RCA_CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [DATA_W-1:0]     add_a_q, add_a_d;
  logic [DATA_W-1:0]     add_b_q, add_b_d;
  logic [DATA_W-1:0]     rsp_sum_q, rsp_sum_d;
  logic                  gnt_id_q, gnt_id_d;

  logic                  idle;
  logic                  advance;
  logic [1:0]            arb_gnt;
  logic                  arb_gnt_id;

  assign idle = (state_q == IDLE);

  // Requests are masked outside IDLE so ready can never rise mid-operation.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0_valid && idle),
    .req1    (req1_valid && idle),
    .advance (advance),
    .gnt     (arb_gnt),
    .gnt_id  (arb_gnt_id)
  );

  assign req0_ready = arb_gnt[0];
  assign req1_ready = arb_gnt[1];
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign rsp_sum    = rsp_sum_q;
  assign busy       = !idle;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    rsp_sum_d    = rsp_sum_q;
    gnt_id_d     = gnt_id_q;
    advance      = 1'b0;
    add_en       = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          add_a_d      = arb_gnt[1] ? req1_a : req0_a;
          add_b_d      = arb_gnt[1] ? req1_b : req0_b;
          gnt_id_d     = arb_gnt_id;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        add_en = 1'b1;
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - RCA_CNT_W'(1);
        end else begin
          rsp_sum_d = add_z;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp0_valid = !gnt_id_q;
        rsp1_valid = gnt_id_q;
        if (gnt_id_q ? rsp1_ready : rsp0_ready) begin
          advance = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_sum_q    <= '0;
      gnt_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      rsp_sum_q    <= rsp_sum_d;
      gnt_id_q     <= gnt_id_d;
    end
  end

endmodule
